led_count_game: RTL and testbench

//  Parametrised LED-count guessing game. A random target from 1 to NUM_LEDS is

---
 rtl/led_game_pkg.sv | 39 +++
 rtl/lfsr16.sv | 36 +++
 rtl/led_count_game.sv | 257 +++++++++++++++++++++++++
 tb/tb_led_count_game.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_game_pkg
// Purpose : Shared definitions for the LED-count guessing game: FSM state
//           encoding, 7-seg glyph nibble codes and a binary to two-digit
//           BCD helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package led_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_JUDGE = 3'd2,
    ST_HINT  = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  // Glyph nibbles understood by the shared 7-seg driver (0-9 are digits).
  localparam logic [3:0] c_glyph_g     = 4'h9;  // '9' doubles as 'g'
  localparam logic [3:0] c_glyph_o     = 4'h0;  // '0' doubles as 'o'
  localparam logic [3:0] c_glyph_n     = 4'hA;
  localparam logic [3:0] c_glyph_l     = 4'hB;
  localparam logic [3:0] c_glyph_d     = 4'hC;
  localparam logic [3:0] c_glyph_u     = 4'hD;
  localparam logic [3:0] c_glyph_p     = 4'hE;
  localparam logic [3:0] c_glyph_blank = 4'hF;

  // Binary 0..99 to {tens, ones} BCD.
  function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
    logic [3:0] tens;
    tens = 4'(bin / 7'd10);
    return {tens, 4'(bin - 7'(tens) * 7'd10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Purpose : 16-bit Fibonacci LFSR, taps 16/15/13/4 (maximal length).
// Ports   : clk     in  1   system clock
//           reset_n in  1   asynchronous active-low reset, loads seed
//           enable  in  1   advance one step per cycle when high
//           seed    in  16  reset value, must be non-zero
//           state   out 16  current LFSR state
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = r_state[15] ^ r_state[14] ^ r_state[12] ^ r_state[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= seed;
    end else if (enable) begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/led_count_game.sv
`default_nettype none
// ============================================================================
// Module  : led_count_game
// Purpose : LED-count guessing game. A random target (1..NUM_LEDS) is shown
//           on the 7-seg while an LED bar animates; the player freezes it
//           with GO/STOP and gets UP/dn hints for up to MAX_TRIES attempts.
// Ports   : clk         in  1        system clock
//           reset_n     in  1        asynchronous active-low reset
//           active      in  1        mode enable; low clears to IDLE
//           btn_go_stop in  1        debounced button level
//           anim_mode   in  1        0 = bounce, 1 = random level per tick
//           led         out NUM_LEDS thermometer bar filled from the MSB
//           seg_data    out 16       four glyph nibbles, [15:12] leftmost
//           tries_left  out 4        attempts remaining this round
//           score       out 7        rounds won, saturating at 99
//           win_pulse   out 1        one-cycle pulse on entry to WIN
//           lose_pulse  out 1        one-cycle pulse on entry to LOSE
// Revision: 1.0 - initial release
// ============================================================================
module led_count_game
  import led_game_pkg::*;
#(
  parameter int          NUM_LEDS    = 16,
  parameter int          TICK_CYCLES = 100_000_000,
  parameter int          MAX_TRIES   = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                active,
  input  logic                btn_go_stop,
  input  logic                anim_mode,
  output logic [NUM_LEDS-1:0] led,
  output logic [15:0]         seg_data,
  output logic [3:0]          tries_left,
  output logic [6:0]          score,
  output logic                win_pulse,
  output logic                lose_pulse
);

  localparam int W   = $clog2(NUM_LEDS + 1);
  localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [TCW-1:0]      c_tick_last = TCW'(TICK_CYCLES - 1);
  localparam logic [W-1:0]        c_level_max = W'(NUM_LEDS);
  localparam logic [W-1:0]        c_level_min = W'(1);
  localparam logic [15:0]         c_num_leds  = 16'(NUM_LEDS);
  localparam logic [3:0]          c_max_tries = 4'(MAX_TRIES);
  localparam logic [6:0]          c_score_max = 7'd99;
  localparam logic [NUM_LEDS-1:0] c_all_on    = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           w_lfsr;
  logic                  r_btn_prev;
  logic                  w_press;
  logic [TCW-1:0]        r_tick_cnt;
  logic                  w_tick;
  logic [W-1:0]          r_target;
  logic [W-1:0]          r_level;
  logic                  r_dir_up;
  logic                  r_shown;     // first tick of a round shows level 1 unchanged
  logic [W-1:0]          w_rand_level;
  logic [W-1:0]          w_step_level;
  logic                  w_step_dir_up;
  logic [NUM_LEDS-1:0]   w_bar;
  logic                  w_hit;
  logic                  w_win_set;
  logic                  w_lose_set;
  logic [3:0]            r_tries;
  logic [6:0]            r_score;
  logic [NUM_LEDS-1:0]   r_led;
  logic [15:0]           r_seg;
  logic [15:0]           w_seg;
  logic [7:0]            w_target_bcd;
  logic [7:0]            w_level_bcd;
  logic                  r_win;
  logic                  r_lose;

  // The LFSR free-runs regardless of mode so the round seed depends on
  // when the player enters the game.
  lfsr16 u_lfsr16 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (1'b1),
    .seed    (LFSR_SEED),
    .state   (w_lfsr)
  );

  assign w_press      = btn_go_stop & ~r_btn_prev;
  assign w_tick       = (r_state == ST_RUN) && (r_tick_cnt == c_tick_last);
  assign w_rand_level = W'(w_lfsr % c_num_leds) + c_level_min;
  assign w_hit        = (r_level == r_target);

  // Next animation level: bounce without repeating the end points, or a
  // fresh random level.
  always_comb begin
    w_step_level  = r_level;
    w_step_dir_up = r_dir_up;
    if (anim_mode) begin
      w_step_level = w_rand_level;
    end else if (r_dir_up) begin
      if (r_level >= c_level_max) begin
        w_step_level  = r_level - c_level_min;
        w_step_dir_up = 1'b0;
      end else begin
        w_step_level  = r_level + c_level_min;
      end
    end else begin
      if (r_level <= c_level_min) begin
        w_step_level  = r_level + c_level_min;
        w_step_dir_up = 1'b1;
      end else begin
        w_step_level  = r_level - c_level_min;
      end
    end
  end

  // Bar for the level about to be displayed.
  assign w_bar = r_shown ? ~(c_all_on >> w_step_level) : ~(c_all_on >> r_level);

  // FSM next state and transition strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_win_set   = 1'b0;
    w_lose_set  = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_press) w_state_nxt = ST_JUDGE;
      ST_JUDGE: begin
        if (w_hit) begin
          w_state_nxt = ST_WIN;
          w_win_set   = 1'b1;
        end else if (r_tries <= 4'd1) begin
          w_state_nxt = ST_LOSE;
          w_lose_set  = 1'b1;
        end else begin
          w_state_nxt = ST_HINT;
        end
      end
      ST_HINT:  if (w_press) w_state_nxt = ST_RUN;
      ST_WIN,
      ST_LOSE:  if (w_press) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!active) begin
      w_state_nxt = ST_IDLE;
      w_win_set   = 1'b0;
      w_lose_set  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Seven-segment formatting from the current registered state.
  assign w_target_bcd = bin_to_bcd2(7'(r_target));
  assign w_level_bcd  = bin_to_bcd2(7'(r_level));

  always_comb begin
    w_seg = {c_glyph_blank, c_glyph_blank, w_target_bcd};
    case (r_state)
      ST_HINT: begin
        if (r_level < r_target) begin
          w_seg = {w_level_bcd, c_glyph_u, c_glyph_p};
        end else begin
          w_seg = {w_level_bcd, c_glyph_d, c_glyph_n};
        end
      end
      ST_WIN:  w_seg = {c_glyph_g, c_glyph_o, c_glyph_o, c_glyph_d};
      ST_LOSE: w_seg = {c_glyph_l, c_glyph_blank, w_target_bcd};
      default: w_seg = {c_glyph_blank, c_glyph_blank, w_target_bcd};
    endcase
  end

  // Datapath: tick divider, level generator, scoring and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev <= 1'b0;
      r_tick_cnt <= '0;
      r_target   <= c_level_min;
      r_level    <= c_level_min;
      r_dir_up   <= 1'b1;
      r_shown    <= 1'b0;
      r_tries    <= c_max_tries;
      r_score    <= '0;
      r_led      <= '0;
      r_seg      <= 16'hFFFF;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_btn_prev <= btn_go_stop;
      r_win      <= w_win_set;
      r_lose     <= w_lose_set;
      if (!active) begin
        r_tick_cnt <= '0;
        r_level    <= c_level_min;
        r_dir_up   <= 1'b1;
        r_shown    <= 1'b0;
        r_tries    <= c_max_tries;
        r_led      <= '0;
        r_seg      <= 16'hFFFF;
      end else begin
        r_seg <= w_seg;
        if (r_state == ST_RUN) begin
          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TCW'(1);
        end else begin
          r_tick_cnt <= '0;
        end
        case (r_state)
          ST_IDLE: begin
            r_target <= w_rand_level;
            r_level  <= c_level_min;
            r_dir_up <= 1'b1;
            r_shown  <= 1'b0;
            r_tries  <= c_max_tries;
            r_led    <= '0;
          end
          ST_RUN: begin
            // A press in the tick cycle wins: the bar stays at the
            // pre-tick level that the player saw.
            if (w_tick && !w_press) begin
              r_led   <= w_bar;
              r_shown <= 1'b1;
              if (r_shown) begin
                r_level  <= w_step_level;
                r_dir_up <= w_step_dir_up;
              end
            end
          end
          ST_JUDGE: begin
            if (w_hit) begin
              if (r_score < c_score_max) r_score <= r_score + 7'd1;
            end else begin
              r_tries <= r_tries - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign led        = r_led;
  assign seg_data   = r_seg;
  assign tries_left = r_tries;
  assign score      = r_score;
  assign win_pulse  = r_win;
  assign lose_pulse = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_led_count_game.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_count_game
// Purpose : Directed self-checking bench for led_count_game with
//           NUM_LEDS=16, TICK_CYCLES=4, MAX_TRIES=3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_count_game;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        active;
  logic        btn_go_stop;
  logic        anim_mode;
  logic [15:0] led;
  logic [15:0] seg_data;
  logic [3:0]  tries_left;
  logic [6:0]  score;
  logic        win_pulse;
  logic        lose_pulse;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_lfsr;
  int          lvl;
  bit          up;

  always #5 clk = ~clk;

  led_count_game #(
    .NUM_LEDS    (16),
    .TICK_CYCLES (4),
    .MAX_TRIES   (3),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .active      (active),
    .btn_go_stop (btn_go_stop),
    .anim_mode   (anim_mode),
    .led         (led),
    .seg_data    (seg_data),
    .tries_left  (tries_left),
    .score       (score),
    .win_pulse   (win_pulse),
    .lose_pulse  (lose_pulse)
  );

  // Reference LFSR: taps 16/15/13/4 expressed as a bit mask.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hD008)};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bar(input int n);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[15-i] = 1'b1;
    return b;
  endfunction

  // Hold the game idle until the free-running LFSR will yield target t,
  // then enable it; returns one cycle after entry to RUN.
  task automatic start_round(input int t);
    int n;
    n = 0;
    active = 1'b0;
    step();
    while ((((m_lfsr % 16) + 1) != t) && (n < 1000)) begin
      step();
      n++;
    end
    total++;
    assert (n < 1000) else begin
      bad++;
      $error("FAIL seed_search: cycles=%0d limit=1000", n);
    end
    active = 1'b1;
    step();
  endtask

  task automatic press();
    btn_go_stop = 1'b1;
    step();
    btn_go_stop = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    active      = 1'b0;
    btn_go_stop = 1'b0;
    anim_mode   = 1'b0;
    #12;
    check("rst_led",   32'(led),        32'h0000);
    check("rst_seg",   32'(seg_data),   32'hFFFF);
    check("rst_tries", 32'(tries_left), 32'd3);
    check("rst_score", 32'(score),      32'd0);
    check("rst_win",   32'(win_pulse),  32'd0);
    check("rst_lose",  32'(lose_pulse), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round 1: target 5, bounce animation.
    start_round(5);
    steps(4);
    check("r1_first_tick", 32'(led),        32'h8000);
    check("r1_seg",        32'(seg_data),   32'hFF05);
    check("r1_tries",      32'(tries_left), 32'd3);
    lvl = 1;
    up  = 1'b1;
    for (int k = 0; k < 32; k++) begin
      lvl = up ? lvl + 1 : lvl - 1;
      if (lvl == 16)     up = 1'b0;
      else if (lvl == 1) up = 1'b1;
      steps(4);
      check($sformatf("bounce%0d", k), 32'(led), 32'(bar(lvl)));
    end

    // Stop at level 3 -> HINT "03UP".
    press();
    step();
    check("hint3_tries", 32'(tries_left), 32'd2);
    step();
    check("hint3_seg",   32'(seg_data),   32'h03DE);
    check("hint3_led",   32'(led),        32'hE000);
    press();
    check("resume_led",  32'(led),        32'hE000);
    steps(4);
    check("resume_l4",   32'(led),        32'hF000);
    steps(4);
    check("resume_l5",   32'(led),        32'hF800);

    // Stop at level 5 -> WIN.
    press();
    step();
    check("win_pulse",   32'(win_pulse),  32'd1);
    check("win_lose",    32'(lose_pulse), 32'd0);
    check("win_score",   32'(score),      32'd1);
    step();
    check("win_pulse_end", 32'(win_pulse), 32'd0);
    check("win_seg",     32'(seg_data),   32'h900C);

    // Round 2: three wrong stops at levels 1, 6, 7 -> LOSE.
    start_round(5);
    check("r2_score_kept", 32'(score), 32'd1);
    steps(4);
    check("r2_l1",       32'(led),        32'h8000);
    press();
    step();
    check("r2_hint1_tries", 32'(tries_left), 32'd2);
    step();
    check("r2_hint1_seg",   32'(seg_data),   32'h01DE);
    press();
    steps(20);
    check("r2_l6",       32'(led),        32'hFC00);
    press();
    step();
    check("r2_hint6_tries", 32'(tries_left), 32'd1);
    step();
    check("r2_hint6_seg",   32'(seg_data),   32'h06CA);
    press();
    steps(4);
    check("r2_l7",       32'(led),        32'hFE00);
    press();
    step();
    check("lose_pulse",  32'(lose_pulse), 32'd1);
    check("lose_win",    32'(win_pulse),  32'd0);
    check("lose_tries",  32'(tries_left), 32'd0);
    step();
    check("lose_pulse_end", 32'(lose_pulse), 32'd0);
    check("lose_seg",    32'(seg_data),   32'hBF05);
    check("lose_led",    32'(led),        32'hFE00);

    // Round 3: press in the tick cycle, then drop active in HINT.
    start_round(9);
    steps(4);
    check("r3_l1",       32'(led),        32'h8000);
    steps(3);
    press();
    check("tick_press_led", 32'(led),     32'h8000);
    step();
    check("r3_tries",    32'(tries_left), 32'd2);
    step();
    check("r3_hint_seg", 32'(seg_data),   32'h01DE);
    active = 1'b0;
    step();
    check("drop_led",    32'(led),        32'h0000);
    check("drop_seg",    32'(seg_data),   32'hFFFF);
    check("drop_tries",  32'(tries_left), 32'd3);
    check("drop_score",  32'(score),      32'd1);

    // Asynchronous reset in the middle of RUN.
    active = 1'b1;
    steps(5);
    check("pre_rst_led", 32'(led),        32'h8000);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_led",   32'(led),        32'h0000);
    check("async_seg",   32'(seg_data),   32'hFFFF);
    check("async_score", 32'(score),      32'd0);
    check("async_tries", 32'(tries_left), 32'd3);
    check("async_win",   32'(win_pulse),  32'd0);
    check("async_lose",  32'(lose_pulse), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
